// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: words, RAM handshake states and memory-arbiter states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // RAM handshake state reported by the memory model/controller.
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    // Memory arbiter FSM states.
    typedef enum logic [2:0] {
        IDLE,
        IACC,
        DACC,
        IRESP,
        DRESP
    } arb_state_t;

    // Word returned to a reader whose RAM access failed or timed out.
    localparam word_t BAD_WORD = 32'hBAD1_BAD1;

endpackage

// File: rtl/mem_arb_timer.sv
// Resettable saturating up-counter; clear has priority over increment.
module mem_arb_timer #(
    parameter int unsigned Width = 4,
    parameter int unsigned Limit = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    localparam logic [Width-1:0] MaxCnt = Width'(Limit);

    logic [Width-1:0] cnt_q, cnt_d;

    // Next count: clear, or step up until the limit and hold there.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter onto a single-ported RAM: one transaction at a time,
// data-first with bounded instruction starvation, and a RAM non-response timeout.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     iaddr,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      ram_err
);

    localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int unsigned TcntW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [StarveW-1:0] StarveLim = StarveW'(STARVE_MAX);
    localparam logic [TcntW-1:0]   TcntLim   = TcntW'(TIMEOUT - 1);

    arb_state_t state_q;
    word_t      req_addr_q, req_store_q;
    logic       req_wr_q;
    logic       ren_q, wen_q;
    word_t      iload_q, dload_q;
    logic       err_q;

    logic [StarveW-1:0] starve_cnt;
    logic [TcntW-1:0]   tcnt;

    logic data_req, in_idle, in_acc;
    logic grant_i, grant_d;
    logic acc_ok, acc_fail;

    // Arbitration and access-completion decode.
    always_comb begin
        data_req = dREN | dWEN;
        in_idle  = (state_q == IDLE);
        in_acc   = (state_q == IACC) || (state_q == DACC);
        // Instruction only wins over a pending data request once starvation hits the cap.
        grant_i  = in_idle && iREN && (!data_req || (starve_cnt == StarveLim));
        grant_d  = in_idle && data_req && !grant_i;
        acc_ok   = in_acc && (ramstate == ACCESS);
        acc_fail = in_acc && !acc_ok && ((ramstate == ERROR) || (tcnt == TcntLim));
    end

    mem_arb_timer #(
        .Width (StarveW),
        .Limit (STARVE_MAX)
    ) u_starve_timer (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (grant_i | (grant_d & ~iREN)),
        .inc_i (grant_d & iREN),
        .cnt_o (starve_cnt)
    );

    mem_arb_timer #(
        .Width (TcntW),
        .Limit (TIMEOUT - 1)
    ) u_access_timer (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (grant_i | grant_d),
        .inc_i (in_acc & ~acc_ok & ~acc_fail),
        .cnt_o (tcnt)
    );

    // Arbiter FSM: latches the winning request, drives registered RAM strobes, captures loads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            req_store_q <= '0;
            req_wr_q    <= 1'b0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            iload_q     <= '0;
            dload_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_i) begin
                        state_q    <= IACC;
                        req_addr_q <= iaddr;
                        req_wr_q   <= 1'b0;
                        ren_q      <= 1'b1;
                        wen_q      <= 1'b0;
                    end else if (grant_d) begin
                        // Both dREN and dWEN high is a write.
                        state_q     <= DACC;
                        req_addr_q  <= daddr;
                        req_store_q <= dstore;
                        req_wr_q    <= dWEN;
                        ren_q       <= ~dWEN;
                        wen_q       <= dWEN;
                    end
                end
                IACC, DACC: begin
                    if (acc_ok || acc_fail) begin
                        if (!req_wr_q) begin
                            if (state_q == IACC) begin
                                iload_q <= acc_ok ? ramload : BAD_WORD;
                            end else begin
                                dload_q <= acc_ok ? ramload : BAD_WORD;
                            end
                        end
                        if (acc_fail) begin
                            err_q <= 1'b1;
                        end
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        state_q <= (state_q == IACC) ? IRESP : DRESP;
                    end
                end
                IRESP, DRESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                end
            endcase
        end
    end

    // Wait releases decode the state register only, so nothing combinational reaches them.
    assign iwait    = (state_q != IRESP);
    assign dwait    = (state_q != DRESP);
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = req_addr_q;
    assign ramstore = req_store_q;
    assign ram_err  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected RAM transactions and
// wait releases into queues; independent monitors pop and compare as the DUT presents them.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK, RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      iwait, dwait;
    word_t     iload, dload;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    logic      ram_err;

    mem_arbiter #(
        .STARVE_MAX (4),
        .TIMEOUT    (64)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .iaddr    (iaddr),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ram_err  (ram_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit    i_port;
        word_t data;
        bit    err;
    } resp_t;

    typedef struct {
        bit    wen;
        word_t addr;
        word_t store;
    } ramtx_t;

    resp_t  resp_q[$];
    ramtx_t ram_q[$];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void push_resp(input bit i_port, input word_t data, input bit err);
        resp_t r;
        r.i_port = i_port;
        r.data   = data;
        r.err    = err;
        resp_q.push_back(r);
    endfunction

    function automatic void push_ram(input bit wen, input word_t addr, input word_t store);
        ramtx_t t;
        t.wen   = wen;
        t.addr  = addr;
        t.store = store;
        ram_q.push_back(t);
    endfunction

    // RAM model: small word array, programmable latency or error reply.
    word_t mem [0:255];
    int    busy_cnt;
    int    ram_delay = 0;
    bit    ram_err_mode = 1'b0;
    logic  strobe;

    assign strobe  = (ramREN === 1'b1) || (ramWEN === 1'b1);
    assign ramload = mem[ramaddr[9:2]];

    always_comb begin
        if (!strobe)                  ramstate = FREE;
        else if (ram_err_mode)        ramstate = ERROR;
        else if (busy_cnt >= ram_delay) ramstate = ACCESS;
        else                          ramstate = BUSY;
    end

    always @(posedge CLK) begin
        busy_cnt <= strobe ? busy_cnt + 1 : 0;
        if (RST) begin
            mem[16] <= 32'h2402_0001;  // 0x40
            mem[17] <= 32'h8C22_0004;  // 0x44
            mem[32] <= 32'h1111_2222;  // 0x80
        end else if (ramWEN === 1'b1 && ramstate == ACCESS) begin
            mem[ramaddr[9:2]] <= ramstore;
        end
    end

    // RAM-side monitor: each new strobe must match the next expected transaction.
    logic prev_strobe = 1'b0;
    always @(negedge CLK) begin
        if (mon_en) begin
            if (ramREN === 1'b1 && ramWEN === 1'b1) check("both_strobes", 32'd1, 32'd0);
            if (strobe && !prev_strobe) begin
                if (ram_q.size() == 0) begin
                    check("unexpected_ram_txn", {31'd0, ramWEN}, 32'hFFFF_FFFF);
                end else begin
                    ramtx_t t;
                    t = ram_q.pop_front();
                    check("ram_wen", {31'd0, ramWEN}, {31'd0, t.wen});
                    check("ram_ren", {31'd0, ramREN}, {31'd0, ~t.wen});
                    check("ram_addr", ramaddr, t.addr);
                    if (t.wen) check("ram_store", ramstore, t.store);
                end
            end
        end
        prev_strobe <= strobe;
    end

    // Response monitor: each wait pulse must match the next expected completion.
    always @(negedge CLK) begin
        if (mon_en && (iwait === 1'b0 || dwait === 1'b0)) begin
            if (iwait === 1'b0 && dwait === 1'b0) check("both_waits_low", 32'd1, 32'd0);
            check("strobes_in_resp", {31'd0, strobe}, 32'd0);
            if (resp_q.size() == 0) begin
                check("unexpected_wait_pulse", {30'd0, iwait, dwait}, 32'h3);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                check("resp_port", {31'd0, (iwait === 1'b0)}, {31'd0, r.i_port});
                check(r.i_port ? "iload" : "dload", r.i_port ? iload : dload, r.data);
                check("ram_err", {31'd0, ram_err}, {31'd0, r.err});
            end
        end
    end

    // Issue one request, optionally drop it early, and check request-to-release latency.
    task automatic run_req(input bit i_port, input bit ren, input bit wen, input word_t addr,
                           input word_t store, input int drop_after, input int exp_lat,
                           input string name);
        int lat;
        bit done;
        @(negedge CLK);
        if (i_port) begin
            iREN  = 1'b1;
            iaddr = addr;
        end else begin
            dREN   = ren;
            dWEN   = wen;
            daddr  = addr;
            dstore = store;
        end
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 200) begin
            @(negedge CLK);
            #1;
            lat++;
            if (lat == drop_after) begin
                iREN = 1'b0;
                dREN = 1'b0;
                dWEN = 1'b0;
            end
            if ((i_port ? iwait : dwait) === 1'b0) done = 1'b1;
        end
        iREN = 1'b0;
        dREN = 1'b0;
        dWEN = 1'b0;
        check(name, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_iwait"}, {31'd0, iwait}, 32'd1);
        check({tag, "_dwait"}, {31'd0, dwait}, 32'd1);
        check({tag, "_iload"}, iload, 32'd0);
        check({tag, "_dload"}, dload, 32'd0);
        check({tag, "_ramaddr"}, ramaddr, 32'd0);
        check({tag, "_ramstore"}, ramstore, 32'd0);
        check({tag, "_ramREN"}, {31'd0, ramREN}, 32'd0);
        check({tag, "_ramWEN"}, {31'd0, ramWEN}, 32'd0);
        check({tag, "_ram_err"}, {31'd0, ram_err}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit done;
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        repeat (2) @(negedge CLK);
        check_reset_values("rst");
        RST = 1'b0;
        mon_en = 1'b1;

        // Instruction fetch, immediate ACCESS.
        push_ram(1'b0, 32'h40, '0);
        push_resp(1'b1, 32'h2402_0001, 1'b0);
        run_req(1'b1, 1'b1, 1'b0, 32'h40, '0, 0, 2, "lat_ifetch");

        // Instruction and data held together: four data grants, then the fetch.
        for (int k = 0; k < 4; k++) begin
            push_ram(1'b0, 32'h80, '0);
            push_resp(1'b0, 32'h1111_2222, 1'b0);
        end
        push_ram(1'b0, 32'h44, '0);
        push_resp(1'b1, 32'h8C22_0004, 1'b0);
        @(negedge CLK);
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h80;
        lat = 0; done = 1'b0;
        while (!done && lat < 100) begin
            @(negedge CLK);
            #1;
            lat++;
            if (iwait === 1'b0) done = 1'b1;
        end
        iREN = 1'b0; dREN = 1'b0;
        check("starve_done", {31'd0, done}, 32'd1);
        check("starve_queue_drained", 32'(resp_q.size()), 32'd0);

        // Write leaves dload alone; read back returns the stored word.
        push_ram(1'b1, 32'h100, 32'hDEAD_BEEF);
        push_resp(1'b0, 32'h1111_2222, 1'b0);
        run_req(1'b0, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 0, 2, "lat_write");
        push_ram(1'b0, 32'h100, '0);
        push_resp(1'b0, 32'hDEAD_BEEF, 1'b0);
        run_req(1'b0, 1'b1, 1'b0, 32'h100, '0, 0, 2, "lat_read_back");

        // dREN and dWEN together behave as a write.
        push_ram(1'b1, 32'h104, 32'hCAFE_F00D);
        push_resp(1'b0, 32'hDEAD_BEEF, 1'b0);
        run_req(1'b0, 1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 0, 2, "lat_both_write");
        push_ram(1'b0, 32'h104, '0);
        push_resp(1'b0, 32'hCAFE_F00D, 1'b0);
        run_req(1'b0, 1'b1, 1'b0, 32'h104, '0, 0, 2, "lat_read_104");

        // RAM answers after three BUSY cycles.
        ram_delay = 3;
        push_ram(1'b0, 32'h80, '0);
        push_resp(1'b0, 32'h1111_2222, 1'b0);
        run_req(1'b0, 1'b1, 1'b0, 32'h80, '0, 0, 5, "lat_delayed");

        // Request dropped mid-access still completes with one pulse.
        push_ram(1'b0, 32'h40, '0);
        push_resp(1'b0, 32'h2402_0001, 1'b0);
        run_req(1'b0, 1'b1, 1'b0, 32'h40, '0, 2, 5, "lat_dropped");
        repeat (4) @(negedge CLK);
        ram_delay = 0;

        // RAM error reply.
        ram_err_mode = 1'b1;
        push_ram(1'b0, 32'h80, '0);
        push_resp(1'b0, BAD_WORD, 1'b1);
        run_req(1'b0, 1'b1, 1'b0, 32'h80, '0, 0, 2, "lat_error");
        ram_err_mode = 1'b0;

        // RAM stuck BUSY: forced completion after 64 access cycles.
        ram_delay = 1000;
        push_ram(1'b0, 32'h84, '0);
        push_resp(1'b0, BAD_WORD, 1'b1);
        run_req(1'b0, 1'b1, 1'b0, 32'h84, '0, 0, 65, "lat_timeout");
        ram_delay = 0;

        // Normal read after errors: flag stays set.
        push_ram(1'b0, 32'h80, '0);
        push_resp(1'b0, 32'h1111_2222, 1'b1);
        run_req(1'b0, 1'b1, 1'b0, 32'h80, '0, 0, 2, "lat_after_err");

        // Reset during a stalled data access: strobe drops, no release pulse.
        ram_delay = 1000;
        push_ram(1'b0, 32'h80, '0);
        @(negedge CLK);
        dREN = 1'b1; daddr = 32'h80;
        repeat (2) @(negedge CLK);
        check("midrst_strobe_before", {31'd0, ramREN}, 32'd1);
        RST = 1'b1; dREN = 1'b0;
        @(negedge CLK);
        check_reset_values("midrst");
        RST = 1'b0;
        ram_delay = 0;
        repeat (6) @(negedge CLK);

        check("resp_queue_empty", 32'(resp_q.size()), 32'd0);
        check("ram_queue_empty", 32'(ram_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Registered memory arbiter sitting directly downstream of the instruction/data cache block. It accepts the cache block's instruction-fetch and data read/write requests and serialises them onto the single-ported RAM. It presents one RAM transaction at a time, returns load data and a per-port wait release, and bounds data-over-instruction starvation and RAM non-response.

## Interface
Parameters:
- STARVE_MAX, 4: maximum consecutive data grants while an instruction request is pending.
- TIMEOUT, 64: cycles in an access state without ACCESS/ERROR before forced error completion.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  reset; one clock, synchronous, active-high.
- iREN  in  1  instruction read request (cache side).
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- iaddr  in  32  instruction address.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- iwait  out  1  low for exactly one cycle when the instruction access completes.
- dwait  out  1  low for exactly one cycle when the data access completes.
- iload  out  32  registered instruction word.
- dload  out  32  registered data word.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- ram_err  out  1  sticky error flag; cleared only by RST.

## Operation
- States: IDLE, IACC, DACC, IRESP, DRESP.
- IDLE, arbitration:
  - Data request (dREN|dWEN) wins unless iREN is high and starve_cnt == STARVE_MAX; then iREN wins.
  - Winner's address, store data and op are latched into request registers.
  - Next state is DACC or IACC.
- starve_cnt:
  - Increments on each data grant made while iREN is high.
  - Clears on any instruction grant, or on a data grant with iREN low.
  - Saturates at STARVE_MAX.
- dREN and dWEN both high: treated as write (dWEN precedence).
- IACC/DACC:
  - Drive ramREN/ramWEN, ramaddr and ramstore from the latched registers only. Later requester input changes are ignored.
  - ramstate ACCESS: capture ramload into iload/dload (reads only), go to IRESP/DRESP.
  - ramstate ERROR, or tcnt reaches TIMEOUT-1: load register := 32'hBAD1_BAD1 (reads only), set ram_err, go to RESP.
  - FREE/BUSY: stay and increment tcnt. tcnt clears on entering any ACC state.
- IRESP/DRESP:
  - The matching wait output is low; all RAM strobes are low.
  - Next state is always IDLE.
- Requester drops its request mid-access:
  - The RAM transaction still completes; writes are never torn.
  - The RESP pulse still occurs; the requester ignores it.
- Writes leave dload unchanged.

## Timing
- Reset values:
  - state IDLE.
  - iwait = dwait = 1.
  - iload = dload = 0, ramaddr = ramstore = 0.
  - ramREN = ramWEN = 0, ram_err = 0.
  - starve_cnt = tcnt = 0.
- iwait = !(state==IRESP); dwait = !(state==DRESP). Decoded from the state register only, so there are no combinational paths from inputs to outputs.
- Latency:
  - Request sampled in IDLE at edge t.
  - RAM strobes driven in cycle t+1.
  - If ACCESS is seen in cycle t+k (k≥1), wait is low in cycle t+k+1 with load data valid.
  - IDLE is re-entered at t+k+2.
  - Minimum request-to-release latency: 2 cycles. Minimum issue interval: 3 cycles.
- Load registers hold their value until the next completion of the same port.
- RST asserted in any state: next edge returns to the reset values. An in-flight RAM strobe drops immediately; no response pulse is issued.

## Structure
- cpu_types_pkg already provides word_t and ramstate_t; reuse both.
- Add arb_state_t (the 5-state enum) and the error constant BAD_WORD = 32'hBAD1_BAD1 to cpu_types_pkg.
- One sub-module is natural: mem_arb_timer, a resettable saturating counter used for both tcnt and starve_cnt (width and limit parameterised).
- The arbiter FSM, request registers and load registers stay in mem_arbiter.

## Test plan
- Instruction only: iREN=1, iaddr=0x40, ramstate ACCESS on first RAM cycle, ramload=0x2402_0001 -> ramREN=1 with ramaddr=0x40 in cycle 1; iwait=0 and iload=0x2402_0001 in cycle 2.
- Simultaneous requests: iREN=1 and dREN=1 (daddr=0x80) held -> data served first. Instruction served after at most STARVE_MAX=4 consecutive data grants while dREN stays high.
- Write then read: dWEN, daddr=0x100, dstore=0xDEAD_BEEF, then dREN at 0x100 with ramload echoing -> ramWEN=1 with ramstore=0xDEAD_BEEF; dload=0xDEAD_BEEF on read completion; dload unchanged after the write.
- RAM error and timeout:
  - ramstate=ERROR on a data read -> dload=0xBAD1_BAD1, dwait pulse, ram_err stays 1.
  - ramstate held BUSY -> completion forced after 64 cycles with the same values.
- Mid-operation events:
  - dREN dropped during DACC -> access completes and a single dwait pulse occurs.
  - RST during DACC -> ramREN=0 and dwait=1 next cycle; no pulse.
